// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: multiply-class command
// encodings (Instr[23:21]), FSM states and the signed-command selector.
package mul_pkg;

    localparam logic [2:0] MUL_CMD   = 3'b000;
    localparam logic [2:0] MLA_CMD   = 3'b001;
    localparam logic [2:0] UMULL_CMD = 3'b100;
    localparam logic [2:0] UMLAL_CMD = 3'b101;
    localparam logic [2:0] SMULL_CMD = 3'b110;
    localparam logic [2:0] SMLAL_CMD = 3'b111;

    // cmd[2:1] value that selects SMULL/SMLAL
    localparam logic [1:0] SIGNED_PREFIX = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        FINISH = 2'b10
    } state_t;

endpackage

// File: rtl/mul_finish.sv
// Combinational completion stage: sign fix of the magnitude product,
// accumulate, result word split and N/Z generation.
module mul_finish
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         cmd,
    input  logic               neg,
    input  logic [2*WIDTH-1:0] product,
    input  logic [WIDTH-1:0]   acc_lo,
    input  logic [WIDTH-1:0]   acc_hi,
    output logic [WIDTH-1:0]   res_lo,
    output logic [WIDTH-1:0]   res_hi,
    output logic               flag_n,
    output logic               flag_z,
    output logic               long_op
);

    logic [2*WIDTH-1:0] fixed;
    logic [2*WIDTH-1:0] sum;
    logic [WIDTH-1:0]   short_sum;

    always_comb begin
        fixed     = neg ? (~product + {{(2*WIDTH-1){1'b0}}, 1'b1}) : product;
        long_op   = (cmd == UMULL_CMD) || (cmd == UMLAL_CMD) ||
                    (cmd == SMULL_CMD) || (cmd == SMLAL_CMD);
        sum       = fixed + (((cmd == UMLAL_CMD) || (cmd == SMLAL_CMD)) ?
                             {acc_hi, acc_lo} : '0);
        // MUL, MLA and the undefined 010/011 encodings share the short path
        short_sum = fixed[WIDTH-1:0] + ((cmd == MLA_CMD) ? acc_lo : '0);
        if (long_op) begin
            res_lo = sum[WIDTH-1:0];
            res_hi = sum[2*WIDTH-1:WIDTH];
            flag_n = sum[2*WIDTH-1];
            flag_z = (sum == '0);
        end else begin
            res_lo = short_sum;
            res_hi = '0;
            flag_n = short_sum[WIDTH-1];
            flag_z = (short_sum == '0);
        end
    end

endmodule

// File: rtl/mul_seq_unit.sv
// Iterative shift-add multiplier for the ARM multiply class.
// Optional macro MUL_EARLY_TERM_EN: leave CALC once the multiplier is exhausted.
module mul_seq_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       cmd,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] acc_hi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             long_op,
    output logic             flags_we,
    output logic             flag_n,
    output logic             flag_z
);

    state_t             state;
    logic [2:0]         cmd_q;
    logic               set_flags_q;
    logic               neg_q;
    logic [WIDTH-1:0]   acc_lo_q;
    logic [WIDTH-1:0]   acc_hi_q;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0]   cnt;

    logic               signed_op;
    logic               last_step;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   fin_lo;
    logic [WIDTH-1:0]   fin_hi;
    logic               fin_n;
    logic               fin_z;
    logic               fin_long;

    always_comb begin
        signed_op = (cmd[2:1] == SIGNED_PREFIX);
        // most-negative input maps onto itself, read back as an unsigned magnitude
        mag_a = (signed_op && op_a[WIDTH-1]) ? (~op_a + {{(WIDTH-1){1'b0}}, 1'b1}) : op_a;
        mag_b = (signed_op && op_b[WIDTH-1]) ? (~op_b + {{(WIDTH-1){1'b0}}, 1'b1}) : op_b;
`ifdef MUL_EARLY_TERM_EN
        last_step = (mplier[WIDTH-1:1] == '0) || (cnt == CNT_W'(WIDTH - 1));
`else
        last_step = (cnt == CNT_W'(WIDTH - 1));
`endif
    end

    mul_finish #(.WIDTH(WIDTH)) u_finish (
        .cmd     (cmd_q),
        .neg     (neg_q),
        .product (prod),
        .acc_lo  (acc_lo_q),
        .acc_hi  (acc_hi_q),
        .res_lo  (fin_lo),
        .res_hi  (fin_hi),
        .flag_n  (fin_n),
        .flag_z  (fin_z),
        .long_op (fin_long)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cmd_q       <= '0;
            set_flags_q <= 1'b0;
            neg_q       <= 1'b0;
            acc_lo_q    <= '0;
            acc_hi_q    <= '0;
            mcand       <= '0;
            mplier      <= '0;
            prod        <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            long_op     <= 1'b0;
            flags_we    <= 1'b0;
            flag_n      <= 1'b0;
            flag_z      <= 1'b0;
        end else begin
            done     <= 1'b0;
            flags_we <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        cmd_q       <= cmd;
                        set_flags_q <= set_flags;
                        neg_q       <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        acc_lo_q    <= acc_lo;
                        acc_hi_q    <= acc_hi;
                        mcand       <= {{WIDTH{1'b0}}, mag_a};
                        mplier      <= mag_b;
                        prod        <= '0;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    if (mplier[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    // busy stays high through the done cycle and drops in IDLE
                    result_lo <= fin_lo;
                    result_hi <= fin_hi;
                    long_op   <= fin_long;
                    flag_n    <= fin_n;
                    flag_z    <= fin_z;
                    flags_we  <= set_flags_q;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mul_seq_unit.md
Name: mul_seq_unit

Overview:
- Iterative shift-add multiplier serving the ARM single-cycle core's multiply class (MUL, MLA, UMULL, UMLAL, SMULL, SMLAL).
- Sits downstream of register-file read and decode, and upstream of result writeback.
- Takes operands Rn, Rm and the accumulator registers. Returns a 32- or 64-bit result plus N/Z flags.
- While busy, the core stalls the PC register.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  request; sampled only in IDLE
cmd  in  3  Instr[23:21]; 000 MUL, 001 MLA, 100 UMULL, 101 UMLAL, 110 SMULL, 111 SMLAL
set_flags  in  1  Instr[20] (S bit)
op_a  in  WIDTH  Rn value
op_b  in  WIDTH  Rm value
acc_lo  in  WIDTH  Ra (MLA) or RdLo (long accumulate)
acc_hi  in  WIDTH  RdHi (long accumulate); ignored otherwise
busy  out  1  high from accepted start until done cycle inclusive
done  out  1  one-cycle pulse; results valid this cycle
result_lo  out  WIDTH  low word / 32-bit result
result_hi  out  WIDTH  high word; 0 for MUL/MLA
long_op  out  1  registered: 1 if result_hi must be written back
flags_we  out  1  equals done & latched set_flags
flag_n  out  1  sign bit of result
flag_z  out  1  result is zero

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy, done, flags_we, flag_n, flag_z, long_op = 0.
  - result_lo, result_hi = 0.
  - All internal registers clear.
  - Reset mid-operation aborts with no done pulse.
- States: IDLE, CALC, FINISH.
- IDLE:
  - On start=1, latch cmd, set_flags and acc_hi/acc_lo.
  - Latch the multiplicand as a 2*WIDTH value and the multiplier as WIDTH bits.
  - Signed cmds (11x): latch |op_a| and |op_b|, and record neg = op_a[MSB] ^ op_b[MSB]. Unsigned and 32-bit cmds latch operands raw.
  - Clear product and counter; go to CALC; busy=1.
- CALC, one step per cycle:
  - If multiplier[0], add multiplicand to product (mod 2^(2*WIDTH)).
  - Shift multiplicand left by 1 and multiplier right by 1; counter++.
  - After WIDTH steps, go to FINISH.
- FINISH:
  - If signed and neg, product = two's-complement negation of product.
  - Accumulate: MLA adds acc_lo to the low word, mod 2^WIDTH. UMLAL/SMLAL add {acc_hi,acc_lo} mod 2^(2*WIDTH).
  - Register result_lo and result_hi. result_hi is forced to 0 for MUL/MLA.
  - done=1 for this one cycle; next state IDLE.
- Result widths:
  - MUL/MLA: result = low WIDTH bits. Signedness is irrelevant.
  - Long ops: full 2*WIDTH bits.
- Flags:
  - MUL/MLA: flag_n = result_lo[WIDTH-1]; flag_z = (result_lo==0).
  - Long ops: flag_n = result_hi[WIDTH-1]; flag_z = ({hi,lo}==0).
  - Flags update only on done; they hold between operations. C and V are not produced.
- Latency: start sampled at edge 0 -> done high in the cycle after edge WIDTH+1 (33 for WIDTH=32).
- Handshakes and edge cases:
  - start while busy (CALC/FINISH) is ignored.
  - Back-to-back: start may be asserted in the cycle after done (IDLE).
  - Operand inputs may change freely after the accept edge.
  - cmd 010/011 (undefined): executed as MUL.
  - Overflow beyond 2*WIDTH wraps silently.
  - Operand = most-negative value in signed mode: the magnitude is treated as an unsigned WIDTH-bit value, so the product stays correct.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- When defined, CALC moves to FINISH as soon as the shifted multiplier becomes zero, with a minimum of one CALC cycle. Latency becomes max(1, bitlen(|op_b|)) + 1 edges after the accept edge. Results are identical.
- When undefined, CALC always runs exactly WIDTH cycles, giving fixed latency WIDTH+1.

Decomposition:
- Shared package mul_pkg holds:
  - cmd encodings: MUL_CMD, MLA_CMD, UMULL_CMD, UMLAL_CMD, SMULL_CMD, SMLAL_CMD.
  - state encoding: IDLE/CALC/FINISH.
  - helper localparam for the signed-cmd test (cmd[2:1]==2'b11).
- One sub-module is natural: mul_finish. It is combinational and does sign-fix, accumulate and N/Z generation. It keeps the FSM file focused on sequencing.
- Registers are inline or reuse flopr/flopenr patterns with an active-low reset.

Test Plan:
- MUL op_a=7, op_b=6, start at edge 0 -> done only in cycle after edge 33; result_lo=42, result_hi=0, busy high edges 1..33.
- MLA op_a=3, op_b=5, acc_lo=10, set_flags=1 -> result_lo=25, flags_we=1, flag_n=0, flag_z=0.
- UMULL 0xFFFFFFFF x 0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, long_op=1.
- SMULL op_a=0xFFFFFFFE (-2), op_b=3, S=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, flag_n=1. Then SMLAL op_a=2, op_b=3, acc={0xFFFFFFFF,0xFFFFFFFA} -> {0,0}, flag_z=1.
- Stress case:
  - Pulse start during CALC: it is ignored and there is exactly one done.
  - Drive reset=0 at edge 10: busy=0 and result=0 immediately, with no done.
  - Issue a new start right after done: it is accepted.
- With MUL_EARLY_TERM_EN: MUL 7x6 -> done after edge 4, result_lo=42; op_b=0 -> done after edge 2, result 0, flag_z=1.
